// File: rtl/sync_fifo_queue.sv
// Single-clock FIFO queue with registered read data; occupancy port under FIFO_COUNT_EN.
// Read data lands one cycle after rd_en; writes into a full queue and reads from an empty one are dropped and flagged for one cycle.
module sync_fifo_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
`ifdef FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;
  logic             rd_acc;
  logic             wr_acc;

  // A read on a full queue frees the slot the same-edge write will fill.
  always_comb begin
    rd_acc  = rd_en && !empty;
    wr_acc  = wr_en && (!full || rd_acc);
    occ_nxt = occ;
    if (wr_acc && !rd_acc) begin
      occ_nxt = occ + (AW+1)'(1);
    end else if (rd_acc && !wr_acc) begin
      occ_nxt = occ - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      data_out  <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      occ       <= occ_nxt;
      full      <= (occ_nxt == FULL_OCC);
      empty     <= (occ_nxt == '0);
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

`ifdef FIFO_COUNT_EN
  assign count = occ;
`endif

endmodule

// File: tb/tb_sync_fifo_queue.sv
// Randomised and directed bench for sync_fifo_queue against a queue-based reference model.
module tb_sync_fifo_queue;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  sync_fifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_ovf  = 1'b0;
  logic             exp_udf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":data_out"},  32'(data_out),  32'(exp_dout));
    chk({tag, ":full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ":empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ":overflow"},  32'(overflow),  32'(exp_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(exp_udf));
`ifdef FIFO_COUNT_EN
    chk({tag, ":count"},     32'(count),     32'(q.size()));
`endif
  endtask

  // Model works on the queue contents as seen before the edge.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [WIDTH-1:0] din);
    bit rd_ok;
    bit wr_ok;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    rd_ok   = rd && (q.size() > 0);
    wr_ok   = wr && ((q.size() < DEPTH) || rd_ok);
    exp_ovf = wr && !wr_ok;
    exp_udf = rd && !rd_ok;
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    @(posedge clk);
    #1;
    check_outputs(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset asserted between edges while a write is being presented.
  task automatic mid_reset(input string tag);
    #2;
    wr_en   = 1'b1;
    data_in = 8'hFF;
    rst_n   = 1'b0;
    #1;
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    check_outputs(tag);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] wlist [6];
    wlist = '{8'h66, 8'h88, 8'hAA, 8'hCC, 8'hEE, 8'h10};

    #12;
    check_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Five writes with idle gaps, then three reads.
    for (int i = 1; i <= 5; i++) begin
      step("w5", 1'b1, 1'b0, 8'(i * 8'h11));
      step("gap", 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) step("r3", 1'b0, 1'b1, 8'h00);
    chk("req33_third", 32'(data_out), 32'h33);

    for (int i = 0; i < 6; i++) step("fill", 1'b1, 1'b0, wlist[i]);
    chk("req34_full", 32'(full), 32'h1);
    step("ovf", 1'b1, 1'b0, 8'h32);
    chk("req34_ovf", 32'(overflow), 32'h1);
    step("ovf_end", 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00);
    chk("req35_last", 32'(data_out), 32'h10);
    for (int i = 0; i < 2; i++) step("udf", 1'b0, 1'b1, 8'h00);
    chk("req35_hold", 32'(data_out), 32'h10);

    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 1'b0, 8'($urandom));
    step("full_rw", 1'b1, 1'b1, 8'h5A);
    chk("req36_full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 8'h00);
    chk("req36_last", 32'(data_out), 32'h5A);

    step("empty_rw", 1'b1, 1'b1, 8'h77);
    chk("req37_udf", 32'(underflow), 32'h1);
    step("rd77", 1'b0, 1'b1, 8'h00);
    chk("req37_data", 32'(data_out), 32'h77);

    for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 8'(8'hA0 + i));
    mid_reset("req38_rst");
    step("post_rst_w", 1'b1, 1'b0, 8'h3C);
    step("post_rst_r", 1'b0, 1'b1, 8'h00);
    chk("req38_first", 32'(data_out), 32'h3C);

    // Random traffic, alternating write-heavy and read-heavy phases to hit both ends.
    for (int i = 0; i < 800; i++) begin
      int wr_pct;
      wr_pct = ((i / 50) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 199) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        step("rnd",
             logic'($urandom_range(0, 99) < wr_pct),
             logic'($urandom_range(0, 99) < (100 - wr_pct)),
             8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_queue.md
SYNC_FIFO_QUEUE -- requirements
Module: sync_fifo_queue

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write request; data_in is enqueued at the tail.
REQ-006 rd_en  input  1  read request; the head entry is dequeued.
REQ-007 data_in  input  WIDTH  write data.
REQ-008 data_out  output  WIDTH  registered read data.
REQ-009 full  output  1  high when occupancy equals DEPTH.
REQ-010 empty  output  1  high when occupancy equals 0.
REQ-011 overflow  output  1  one-cycle pulse on a rejected write.
REQ-012 underflow  output  1  one-cycle pulse on a rejected read.
REQ-013 count  output  log2(DEPTH)+1  occupancy; present only with FIFO_COUNT_EN.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH registers addressed by a write pointer and a read pointer, each log2(DEPTH) bits wide.
REQ-015 Ordering SHALL be first-in first-out: entries are read in the same order they were written.
REQ-016 An accepted write SHALL store data_in at the write pointer and advance the pointer by 1, wrapping from DEPTH-1 to 0.
REQ-017 An accepted read SHALL load the entry at the read pointer into data_out on the same edge and advance the pointer by 1, wrapping from DEPTH-1 to 0.
REQ-018 Read latency SHALL be 1 cycle: data_out is valid in the cycle after the edge at which rd_en is sampled high with empty low.
REQ-019 data_out SHALL hold its last value in every cycle without an accepted read.
REQ-020 A write SHALL be accepted when wr_en=1 and either full=0 or rd_en=1 is accepted on the same edge.
REQ-021 A read SHALL be accepted when rd_en=1 and empty=0; a read is never accepted from an empty queue, and there is no write-to-read bypass.
REQ-022 wr_en=1 with full=1 and rd_en=0: the write SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL pulse high for 1 cycle.
REQ-023 rd_en=1 with empty=1: the read SHALL be dropped, data_out SHALL be unchanged, and underflow SHALL pulse high for 1 cycle; a simultaneous write SHALL still be accepted.
REQ-024 Simultaneous accepted read and write SHALL leave occupancy unchanged; when full, the read returns the oldest entry and the write fills the freed slot.
REQ-025 Occupancy SHALL be an internal counter of log2(DEPTH)+1 bits: +1 on a write-only edge, -1 on a read-only edge, unchanged otherwise; it never exceeds DEPTH or goes below 0.
REQ-026 full and empty SHALL be registered decodes of the occupancy counter, valid in the cycle after the edge that changes occupancy.

Reset
REQ-027 rst_n=0 SHALL immediately clear both pointers and the occupancy counter to 0, and set data_out to 0, full to 0, empty to 1, overflow to 0 and underflow to 0.
REQ-028 Storage array contents SHALL NOT be reset.
REQ-029 Assertion of rst_n mid-operation SHALL abort any in-flight access; after reset the queue is empty and the first read returns the first word written after reset.
REQ-030 Release of rst_n SHALL take effect at the next rising clk edge.

Configuration
REQ-031 Macro FIFO_COUNT_EN defined: the count port SHALL exist and drive the internal occupancy counter (reset value 0).
REQ-032 Macro FIFO_COUNT_EN undefined: the count port SHALL be absent, with no other functional change.

Verification
REQ-033 Reset, then write 11,22,33,44,55 with one-cycle gaps -> count=5, empty=0, full=0; then read 3 -> data_out returns 11,22,33 in order, count=2.
REQ-034 Write 66,88,AA,CC,EE,10 -> full=1 after the 6th write; a 7th write of 32 -> overflow pulses 1 cycle and the contents are unchanged.
REQ-035 Read 8 times starting from full -> data_out returns 44,55,66,88,AA,CC,EE,10; empty=1 after the 8th read is issued; the extra reads pulse underflow and data_out holds 10.
REQ-036 Full queue, wr_en=1 and rd_en=1 on the same edge with data_in=5A -> the oldest entry is returned, full stays 1, and 5A is read last.
REQ-037 Empty queue, wr_en=1 and rd_en=1 with data_in=77 -> underflow pulses, count=1, and the next read returns 77.
REQ-038 rst_n pulled low mid-burst after 3 writes -> empty=1 and data_out=0 immediately (asynchronous); pointers wrap correctly across more than DEPTH subsequent writes and reads.
